// File: rtl/riscv_mem_pkg.sv
// Shared types and lane helpers for the load/store memory stage.
// Enumerations cover the memory op, access size and stage FSM state.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Halfwords pick their lane from offset[1] only, so an unchecked
    // misaligned half falls back onto the aligned half it sits in.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size,
                                                input logic        zero_ext);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: result = zero_ext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = zero_ext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:   result = rdata;
        endcase
        return result;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication across lanes,
// and load lane extraction with sign/zero extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    assign be        = be_gen(size, offset);
    assign load_data = load_extend(rdata, offset, size, zero_ext);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[8*gi +: 8] = (size == SIZE_BYTE) ? store_data[7:0] :
                                      (size == SIZE_HALF) ? store_data[8*(gi%2) +: 8] :
                                                            store_data[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// Load/store memory stage: IDLE -> REQ -> WAIT handshake with the data memory.
// Optional MEM_STAGE_MISALIGN_CHECK_EN drops misaligned half/word accesses.
module mem_stage
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic [1:0]      ex_mem_op,
    input  logic [1:0]      ex_size,
    input  logic            ex_unsigned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    output logic            misalign_o,
`endif
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] wb_alu_res,
    output logic [4:0]      wb_rd,
    output logic            wb_is_load
);

    state_e          state_reg;
    state_e          state_next;
    logic [XLEN-1:0] alu_res_reg;
    logic [XLEN-1:0] store_data_reg;
    logic [4:0]      rd_reg;
    logic [1:0]      op_reg;
    logic [1:0]      size_reg;
    logic            zero_ext_reg;
    logic [XLEN-1:0] load_data;
    logic            is_mem;
    logic            misaligned;

    assign is_mem = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(ex_size, ex_alu_res[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (ex_valid && is_mem && !misaligned) state_next = ST_REQ;
            ST_REQ:  if (dmem_gnt)                          state_next = ST_WAIT;
            ST_WAIT: if (dmem_rvalid)                       state_next = ST_IDLE;
            default:                                        state_next = ST_IDLE;
        endcase
    end

    // Lane logic works only from latched fields so the bus stays stable in REQ.
    mem_lane_align u_lane_align (
        .size       (size_reg),
        .offset     (alu_res_reg[1:0]),
        .zero_ext   (zero_ext_reg),
        .store_data (store_data_reg),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    assign ex_ready  = (state_reg == ST_IDLE);
    assign dmem_req  = (state_reg == ST_REQ);
    assign dmem_we   = dmem_req && (op_reg == MEM_STORE);
    assign dmem_addr = {alu_res_reg[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            alu_res_reg    <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            op_reg         <= '0;
            size_reg       <= '0;
            zero_ext_reg   <= 1'b0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_alu_res     <= '0;
            wb_rd          <= '0;
            wb_is_load     <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            misalign_o     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            wb_valid  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (ex_valid && !is_mem) begin
                        wb_valid   <= 1'b1;
                        wb_data    <= '0;
                        wb_is_load <= 1'b0;
                        wb_alu_res <= ex_alu_res;
                        wb_rd      <= ex_rd;
                    end else if (ex_valid && misaligned) begin
                        // Dropped access: retire with rd=0 so nothing is written.
                        wb_valid   <= 1'b1;
                        wb_data    <= '0;
                        wb_is_load <= 1'b0;
                        wb_alu_res <= ex_alu_res;
                        wb_rd      <= '0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
                        misalign_o <= 1'b1;
`endif
                    end else if (ex_valid) begin
                        alu_res_reg    <= ex_alu_res;
                        store_data_reg <= ex_store_data;
                        rd_reg         <= ex_rd;
                        op_reg         <= ex_mem_op;
                        size_reg       <= ex_size;
                        zero_ext_reg   <= ex_unsigned;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid   <= 1'b1;
                        wb_is_load <= (op_reg == MEM_LOAD);
                        wb_data    <= (op_reg == MEM_LOAD) ? load_data : '0;
                        wb_alu_res <= alu_res_reg;
                        wb_rd      <= rd_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores against a byte-array reference memory.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] wb_alu_res;
    logic [4:0]  wb_rd;
    logic        wb_is_load;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] bus_mem [64];

    mem_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_res    (ex_alu_res),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_mem_op     (ex_mem_op),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        .misalign_o    (misalign_o),
`endif
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_alu_res    (wb_alu_res),
        .wb_rd         (wb_rd),
        .wb_is_load    (wb_is_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        bus_mem[idx] = val;
        for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = val[8*b +: 8];
    endtask

    // One load/store with chosen grant/response delays; expectations come
    // from the byte-level reference memory and the access-size rules.
    task automatic mem_txn(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input string tag);
        int          n;
        int          eoff;
        int          base;
        longint      v;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic [31:0] exp_addr;
        logic [31:0] exp_wb;

        n         = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        eoff      = (int'(addr[1:0]) / n) * n;
        base      = int'(addr[7:0]) - int'(addr[1:0]);
        exp_be    = 4'(((1 << n) - 1) << eoff);
        exp_wdata = (n == 1) ? {4{sd[7:0]}} : (n == 2) ? {2{sd[15:0]}} : sd;
        exp_addr  = {addr[31:2], 2'b00};
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[base + eoff + i]) << (8*i));
        if (!uns && v[8*n-1]) v = v - (longint'(1) << (8*n));
        exp_load = v[31:0];
        exp_wb   = (op == 2'd1) ? exp_load : 32'h0;

        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b want 1", tag, ex_ready);
        end
        ex_valid = 1'b1; ex_mem_op = op; ex_size = size; ex_unsigned = uns;
        ex_alu_res = addr; ex_store_data = sd; ex_rd = rd;

        @(negedge clk);
        // Busy-time garbage on EX must not be taken.
        ex_valid = 1'b1; ex_mem_op = 2'd0; ex_alu_res = $urandom; ex_store_data = $urandom;
        ex_rd = 5'($urandom); ex_size = 2'($urandom_range(0, 2)); ex_unsigned = 1'($urandom);
        for (int k = 0; k < gnt_dly; k++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be ||
                ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s req_hold: req=%b addr=%h be=%b ready=%b wbv=%b want 1 %h %b 0 0",
                         tag, dmem_req, dmem_addr, dmem_be, ex_ready, wb_valid, exp_addr, exp_be);
            end
            dmem_rvalid = (k == 0);
            dmem_rdata  = $urandom;
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be ||
            dmem_we !== (op == 2'd2) || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s req: req=%b addr=%h be=%b we=%b ready=%b wbv=%b want 1 %h %b %b 0 0",
                     tag, dmem_req, dmem_addr, dmem_be, dmem_we, ex_ready, wb_valid,
                     exp_addr, exp_be, (op == 2'd2));
        end
        if (op == 2'd2) begin
            checks++;
            if (dmem_wdata !== exp_wdata) begin
                errors++; $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, exp_wdata);
            end
            for (int b = 0; b < 4; b++)
                if (dmem_be[b]) bus_mem[dmem_addr[7:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        for (int k = 0; k < rv_dly; k++) begin
            checks++;
            if (dmem_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s wait: req=%b ready=%b wbv=%b want 0 0 0",
                         tag, dmem_req, ex_ready, wb_valid);
            end
            dmem_gnt = (k == 0);
            @(negedge clk);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = (op == 2'd1) ? bus_mem[addr[7:2]] : $urandom;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        ex_valid    = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== rd || wb_is_load !== (op == 2'd1) ||
            wb_data !== exp_wb || wb_alu_res !== addr) begin
            errors++;
            $display("FAIL %s wb: v=%b rd=%0d ld=%b data=%h alu=%h want 1 %0d %b %h %h",
                     tag, wb_valid, wb_rd, wb_is_load, wb_data, wb_alu_res,
                     rd, (op == 2'd1), exp_wb, addr);
        end
        if (op == 2'd2)
            for (int i = 0; i < n; i++) ref_mem[base + eoff + i] = sd[8*i +: 8];
        $display("txn %s op=%0d size=%0d uns=%0d addr=%h be=%b wb_data=%h",
                 tag, op, size, uns, addr, exp_be, wb_data);

        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s wb_pulse: wbv=%b ready=%b want 0 1", tag, wb_valid, ex_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ex_valid = 1'b0; ex_mem_op = '0; ex_size = '0; ex_unsigned = 1'b0;
        ex_alu_res = '0; ex_store_data = '0; ex_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || wb_is_load !== 1'b0 ||
            wb_data !== 32'h0 || wb_alu_res !== 32'h0 || wb_rd !== 5'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b wbv=%b ld=%b data=%h alu=%h rd=%0d want all 0",
                     dmem_req, wb_valid, wb_is_load, wb_data, wb_alu_res, wb_rd);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL reset_release: ready=%b req=%b want 1 0", ex_ready, dmem_req);
        end
        $display("txn reset done");
    endtask

    task automatic test_store_word;
        mem_txn(2'd2, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 0, 0, "sw_0x100");
        mem_txn(2'd1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 0, 0, "lw_0x100");
    endtask

    task automatic test_load_byte;
        set_word(0, 32'h80A1_B2C3);
        mem_txn(2'd1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd3, 0, 0, "lb_0x103");
        mem_txn(2'd1, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd4, 0, 0, "lbu_0x103");
        checks++;
        if (wb_data !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_const: got %h want 00000080", wb_data);
        end
    endtask

    task automatic test_load_half_gnt;
        set_word(0, 32'h8765_1234);
        mem_txn(2'd1, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 5'd11, 4, 0, "lh_0x102_gnt4");
        checks++;
        if (wb_data !== 32'hFFFF_8765) begin
            errors++; $display("FAIL lh_const: got %h want ffff8765", wb_data);
        end
    endtask

    task automatic test_alu_back_to_back;
        logic [4:0]  rds  [5];
        logic [31:0] alus [5];
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_rd !== rds[i-1] || wb_alu_res !== alus[i-1] ||
                    wb_data !== 32'h0 || wb_is_load !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_stream[%0d]: v=%b rd=%0d alu=%h data=%h ld=%b want 1 %0d %h 0 0",
                             i-1, wb_valid, wb_rd, wb_alu_res, wb_data, wb_is_load, rds[i-1], alus[i-1]);
                end
                $display("txn alu rd=%0d alu_res=%h", rds[i-1], alus[i-1]);
            end
            checks++;
            if (ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL alu_idle[%0d]: ready=%b req=%b want 1 0", i, ex_ready, dmem_req);
            end
            if (i < 5) begin
                rds[i] = 5'($urandom); alus[i] = $urandom;
                ex_valid = 1'b1; ex_mem_op = 2'd0; ex_alu_res = alus[i]; ex_rd = rds[i];
                ex_store_data = $urandom; ex_size = 2'($urandom_range(0, 2));
            end else begin
                ex_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL alu_stream_end: wbv=%b want 0", wb_valid);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_op = 2'd1; ex_size = 2'd2; ex_unsigned = 1'b0;
        ex_alu_res = 32'h0000_0040; ex_rd = 5'd13;
        @(negedge clk);
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b0) begin
            errors++; $display("FAIL rst_wait_pre: req=%b ready=%b want 0 0", dmem_req, ex_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_rd !== 5'h0) begin
            errors++;
            $display("FAIL rst_wait_during: wbv=%b req=%b ready=%b rd=%0d want 0 0 1 0",
                     wb_valid, dmem_req, ex_ready, wb_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_late_rvalid: wbv=%b req=%b ready=%b want 0 0 1",
                     wb_valid, dmem_req, ex_ready);
        end
        $display("txn reset_in_wait done");
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  op;
            logic [1:0]  size;
            logic [31:0] addr;
            op   = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            size = 2'($urandom_range(0, 2));
            addr = $urandom;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            if (size == 2'd1) addr[0] = 1'b0;
            if (size == 2'd2) addr[1:0] = 2'b00;
`endif
            mem_txn(op, size, 1'($urandom), addr, $urandom, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
    endtask

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    task automatic test_misalign;
        logic [1:0]  sizes [2];
        logic [31:0] addrs [2];
        sizes[0] = 2'd2; addrs[0] = 32'h0000_0102;
        sizes[1] = 2'd1; addrs[1] = 32'h0000_0101;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ex_valid = 1'b1; ex_mem_op = 2'd1; ex_size = sizes[i]; ex_alu_res = addrs[i]; ex_rd = 5'd9;
            @(negedge clk);
            ex_valid = 1'b0;
            checks++;
            if (dmem_req !== 1'b0 || misalign_o !== 1'b1 || wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL misalign[%0d]: req=%b mis=%b wbv=%b ready=%b want 0 1 1 1",
                         i, dmem_req, misalign_o, wb_valid, ex_ready);
            end
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b0 || misalign_o !== 1'b0 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_after[%0d]: req=%b mis=%b wbv=%b want 0 0 0",
                         i, dmem_req, misalign_o, wb_valid);
            end
            $display("txn misalign size=%0d addr=%h", sizes[i], addrs[i]);
        end
    endtask
`endif

    initial begin
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half_gnt();
        test_alu_back_to_back();
        test_reset_in_wait();
        test_random();
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
